// File: rtl/uart_bus_loader.sv
// uart_bus_loader
//    UART-driven bus initiator. Parses byte commands from the UART RX stream
//    and turns them into single-byte writes and reads on the CPU valid/ready
//    bus. Every command ends with exactly one ACK (0x06) or NAK (0x15) byte.
//    While o_hold is 1 the core is held and the loader owns the bus.
//
//    Commands (multi-byte fields little-endian; an N byte of 0 means 256):
//       'W' A0..A3 N D0..D(N-1)   write Di to A+i, then ACK
//       'R' A0..A3 N              read N bytes from A+i, echo on TX, then ACK
//       'G'                       ACK, then release the core (o_hold = 0)
//       'H'                       ACK, then hold the core (o_hold = 1)
//       anything else             NAK ('W'/'R' are also NAK'd while released)
//
// Ports
//    i_clk, i_rst                clock, synchronous active-high reset
//    i_rx_data/i_rx_valid        RX byte stream in, o_rx_ready back-pressure
//    o_tx_data/o_tx_valid        TX byte stream out, i_tx_ready back-pressure
//    o_addr, o_data, o_wr_width  bus byte address, write data, write size (1 byte)
//    o_wr_valid/i_wr_ready       write request handshake
//    o_rd_ready/i_rd_valid       read request handshake, i_data is read data
//    o_hold                      core held / bus owned by the loader
//
// States
//    state   | meaning
//    --------+-----------------------------------------------------------
//    IDLE    | waiting for an opcode byte
//    ADDR    | collecting address bytes A0..A3 (idx_q counts 0..3)
//    LEN     | collecting the N byte
//    WDATA   | waiting for the next write data byte
//    WBUS    | write request on the bus, waiting for i_wr_ready
//    RBUS    | read request on the bus, waiting for i_rd_valid
//    RTX     | sending the byte just read
//    RESP    | sending the ACK/NAK byte; G/H update o_hold on its accept

module uart_bus_loader #(
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [7:0]            i_rx_data,
   input  logic                  i_rx_valid,
   output logic                  o_rx_ready,
   output logic [7:0]            o_tx_data,
   output logic                  o_tx_valid,
   input  logic                  i_tx_ready,
   output logic [31:0]           o_addr,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_wr_valid,
   input  logic                  i_wr_ready,
   output logic [2:0]            o_wr_width,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_rd_valid,
   output logic                  o_rd_ready,
   output logic                  o_hold
);

   localparam logic [7:0] OP_W = 8'h57;
   localparam logic [7:0] OP_R = 8'h52;
   localparam logic [7:0] OP_G = 8'h47;
   localparam logic [7:0] OP_H = 8'h48;
   localparam logic [7:0] ACK  = 8'h06;
   localparam logic [7:0] NAK  = 8'h15;

   // Inter-byte timer: down-counter reloaded on every accepted byte and on
   // every cycle outside the timed states; expiry is the terminal count 0.
   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_LEN,
      S_WDATA,
      S_WBUS,
      S_RBUS,
      S_RTX,
      S_RESP
   } state_t;

   state_t        state_q;
   state_t        state_d;

   logic [31:0]   addr_q;
   logic [7:0]    data_q;
   logic [7:0]    tx_data_q;
   logic [8:0]    cnt_q;
   logic [1:0]    idx_q;
   logic [TW-1:0] tmo_q;
   logic          cmd_wr_q;
   logic          set_hold_q;
   logic          clr_hold_q;
   logic          hold_q;

   logic          rx_acc;
   logic          tx_acc;
   logic          wr_acc;
   logic          rd_acc;
   logic          timed;
   logic          tmo_exp;
   logic          is_w;
   logic          is_r;
   logic          is_g;
   logic          is_h;
   logic          op_bus;
   logic          last_byte;

   // Only the low byte of read data carries payload.
   logic          unused_rd_hi;
   assign unused_rd_hi = ^i_data[DATA_WIDTH-1:8];

   assign rx_acc    = o_rx_ready & i_rx_valid;
   assign tx_acc    = o_tx_valid & i_tx_ready;
   assign wr_acc    = o_wr_valid & i_wr_ready;
   assign rd_acc    = o_rd_ready & i_rd_valid;

   assign is_w      = (i_rx_data == OP_W);
   assign is_r      = (i_rx_data == OP_R);
   assign is_g      = (i_rx_data == OP_G);
   assign is_h      = (i_rx_data == OP_H);
   assign op_bus    = (is_w | is_r) & hold_q;
   assign last_byte = (cnt_q == 9'd1);

   assign timed     = (state_q == S_ADDR) || (state_q == S_LEN) || (state_q == S_WDATA);
   assign tmo_exp   = timed && !rx_acc && (tmo_q == '0);

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (rx_acc) state_d = op_bus ? S_ADDR : S_RESP;
         end
         S_ADDR: begin
            if (rx_acc) begin
               if (idx_q == 2'd3) state_d = S_LEN;
            end else if (tmo_exp) begin
               state_d = S_IDLE;
            end
         end
         S_LEN: begin
            if (rx_acc)       state_d = cmd_wr_q ? S_WDATA : S_RBUS;
            else if (tmo_exp) state_d = S_IDLE;
         end
         S_WDATA: begin
            if (rx_acc)       state_d = S_WBUS;
            else if (tmo_exp) state_d = S_IDLE;
         end
         S_WBUS: begin
            if (wr_acc) state_d = last_byte ? S_RESP : S_WDATA;
         end
         S_RBUS: begin
            if (rd_acc) state_d = S_RTX;
         end
         S_RTX: begin
            if (tx_acc) state_d = last_byte ? S_RESP : S_RBUS;
         end
         S_RESP: begin
            if (tx_acc) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      o_rx_ready = 1'b0;
      o_tx_valid = 1'b0;
      o_wr_valid = 1'b0;
      o_rd_ready = 1'b0;
      case (state_q)
         S_IDLE, S_ADDR, S_LEN, S_WDATA: o_rx_ready = !i_rst;
         S_WBUS:                         o_wr_valid = hold_q;
         S_RBUS:                         o_rd_ready = hold_q;
         S_RTX, S_RESP:                  o_tx_valid = 1'b1;
         default: ;
      endcase
      o_tx_data  = tx_data_q;
      o_addr     = addr_q;
      o_data     = {{(DATA_WIDTH-8){1'b0}}, data_q};
      o_wr_width = 3'b001;
      o_hold     = hold_q;
   end

   // Datapath: address, count, data and response registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         addr_q     <= '0;
         data_q     <= '0;
         tx_data_q  <= '0;
         cnt_q      <= '0;
         idx_q      <= '0;
         cmd_wr_q   <= 1'b0;
         set_hold_q <= 1'b0;
         clr_hold_q <= 1'b0;
         hold_q     <= 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (rx_acc) begin
                  cmd_wr_q   <= is_w;
                  idx_q      <= 2'd0;
                  // Only meaningful when going to RESP; a bus command
                  // overwrites it before any byte is sent.
                  tx_data_q  <= (is_g | is_h) ? ACK : NAK;
                  set_hold_q <= is_h;
                  clr_hold_q <= is_g;
               end
            end
            S_ADDR: begin
               if (rx_acc) begin
                  addr_q[8*idx_q +: 8] <= i_rx_data;
                  idx_q                <= idx_q + 2'd1;
               end
            end
            S_LEN: begin
               if (rx_acc) cnt_q <= (i_rx_data == 8'd0) ? 9'd256 : {1'b0, i_rx_data};
            end
            S_WDATA: begin
               if (rx_acc) data_q <= i_rx_data;
            end
            S_WBUS: begin
               if (wr_acc) begin
                  addr_q <= addr_q + 32'd1;
                  cnt_q  <= cnt_q - 9'd1;
                  if (last_byte) tx_data_q <= ACK;
               end
            end
            S_RBUS: begin
               if (rd_acc) tx_data_q <= i_data[7:0];
            end
            S_RTX: begin
               if (tx_acc) begin
                  addr_q <= addr_q + 32'd1;
                  cnt_q  <= cnt_q - 9'd1;
                  if (last_byte) tx_data_q <= ACK;
               end
            end
            S_RESP: begin
               if (tx_acc) begin
                  if (set_hold_q) hold_q <= 1'b1;
                  if (clr_hold_q) hold_q <= 1'b0;
                  set_hold_q <= 1'b0;
                  clr_hold_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Inter-byte timeout counter
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         tmo_q <= '0;
      end else if (rx_acc || !timed) begin
         tmo_q <= TMO_LOAD;
      end else if (tmo_q != '0) begin
         tmo_q <= tmo_q - 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_bus_loader.sv
module tb_uart_bus_loader;

   localparam int DW  = 32;
   localparam int TMO = 40;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic [7:0]    i_rx_data;
   logic          i_rx_valid;
   logic          o_rx_ready;
   logic [7:0]    o_tx_data;
   logic          o_tx_valid;
   logic          i_tx_ready;
   logic [31:0]   o_addr;
   logic [DW-1:0] o_data;
   logic          o_wr_valid;
   logic          i_wr_ready;
   logic [2:0]    o_wr_width;
   logic [DW-1:0] i_data;
   logic          i_rd_valid;
   logic          o_rd_ready;
   logic          o_hold;

   int n_total = 0;
   int n_bad   = 0;
   int viol    = 0;
   int stable_bad;

   logic [7:0]  txq[$];
   logic [31:0] waq[$];
   logic [31:0] wdq[$];
   logic [2:0]  wwq[$];
   logic [31:0] raq[$];

   uart_bus_loader #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
      .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
      .o_addr(o_addr), .o_data(o_data), .o_wr_valid(o_wr_valid), .i_wr_ready(i_wr_ready),
      .o_wr_width(o_wr_width), .i_data(i_data), .i_rd_valid(i_rd_valid),
      .o_rd_ready(o_rd_ready), .o_hold(o_hold)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [7:0] mem_rd(input logic [31:0] a);
      if (a == 32'hFFFF_FFFF) return 8'h11;
      if (a == 32'h0000_0000) return 8'h22;
      return a[7:0] ^ 8'h5A;
   endfunction

   assign i_data = {24'h0, mem_rd(o_addr)};

   // Inputs change only at posedge+1, so values seen at negedge are the
   // ones the DUT sees at the following posedge.
   always @(negedge i_clk) begin
      if (o_tx_valid && i_tx_ready) txq.push_back(o_tx_data);
      if (o_wr_valid && i_wr_ready) begin
         waq.push_back(o_addr);
         wdq.push_back(o_data);
         wwq.push_back(o_wr_width);
      end
      if (o_rd_ready && i_rd_valid) raq.push_back(o_addr);
      if (o_wr_valid && o_rd_ready) viol++;
      if (!o_hold && (o_wr_valid || o_rd_ready)) viol++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit done = 0;
      i_rx_data  = b;
      i_rx_valid = 1'b1;
      for (int k = 0; k < 2000 && !done; k++) begin
         @(negedge i_clk);
         if (o_rx_ready) done = 1;
         tick();
      end
      i_rx_valid = 1'b0;
      if (!done) check("rx_accept_bound", {31'd0, o_rx_ready}, 32'd1);
   endtask

   task automatic send_seq(input logic [7:0] s[]);
      foreach (s[i]) send_byte(s[i]);
   endtask

   task automatic wait_tx(input int n);
      for (int k = 0; k < 3000 && txq.size() < n; k++) tick();
   endtask

   task automatic clear_q();
      txq.delete(); waq.delete(); wdq.delete(); wwq.delete(); raq.delete();
   endtask

   initial begin
      i_rst      = 1'b1;
      i_rx_data  = 8'h00;
      i_rx_valid = 1'b0;
      i_tx_ready = 1'b1;
      i_wr_ready = 1'b1;
      i_rd_valid = 1'b1;
      repeat (3) tick();
      @(negedge i_clk);
      check("rx_ready_in_reset", {31'd0, o_rx_ready}, 32'd0);
      check("rst_hold", {31'd0, o_hold}, 32'd1);
      check("rst_tx_valid", {31'd0, o_tx_valid}, 32'd0);
      check("rst_wr_valid", {31'd0, o_wr_valid}, 32'd0);
      check("rst_rd_ready", {31'd0, o_rd_ready}, 32'd0);
      check("rst_addr", o_addr, 32'h0);
      check("rst_data", o_data, 32'h0);
      check("rst_tx_data", {24'd0, o_tx_data}, 32'h0);
      tick();
      i_rst = 1'b0;
      tick();
      clear_q();

      // Two-byte write, zero-wait bus
      send_seq('{8'h57, 8'h00, 8'h10, 8'h00, 8'h00, 8'h02, 8'hAA, 8'hBB});
      wait_tx(1);
      repeat (3) tick();
      check("w1_count", waq.size(), 2);
      if (waq.size() == 2) begin
         check("w1_addr0", waq[0], 32'h0000_1000);
         check("w1_data0", wdq[0], 32'h0000_00AA);
         check("w1_width0", {29'd0, wwq[0]}, 32'd1);
         check("w1_addr1", waq[1], 32'h0000_1001);
         check("w1_data1", wdq[1], 32'h0000_00BB);
         check("w1_width1", {29'd0, wwq[1]}, 32'd1);
      end
      check("w1_tx_count", txq.size(), 1);
      if (txq.size() >= 1) check("w1_ack", {24'd0, txq[0]}, 32'h06);
      clear_q();

      // Read across the address wrap
      send_seq('{8'h52, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02});
      wait_tx(3);
      repeat (3) tick();
      check("r1_count", raq.size(), 2);
      if (raq.size() == 2) begin
         check("r1_addr0", raq[0], 32'hFFFF_FFFF);
         check("r1_addr1", raq[1], 32'h0000_0000);
      end
      check("r1_tx_count", txq.size(), 3);
      if (txq.size() == 3) begin
         check("r1_tx0", {24'd0, txq[0]}, 32'h11);
         check("r1_tx1", {24'd0, txq[1]}, 32'h22);
         check("r1_tx2", {24'd0, txq[2]}, 32'h06);
      end
      clear_q();

      // Stalled write and stalled ACK
      i_wr_ready = 1'b0;
      i_tx_ready = 1'b0;
      send_seq('{8'h57, 8'h00, 8'h20, 8'h00, 8'h00, 8'h01, 8'h5C});
      stable_bad = 0;
      repeat (5) begin
         @(negedge i_clk);
         if (!(o_wr_valid && o_addr == 32'h2000 && o_data == 32'h5C)) stable_bad++;
         tick();
      end
      check("w2_stable", stable_bad, 0);
      i_wr_ready = 1'b1;
      tick();
      stable_bad = 0;
      repeat (3) begin
         @(negedge i_clk);
         if (!(o_tx_valid && o_tx_data == 8'h06) || o_wr_valid) stable_bad++;
         tick();
      end
      check("w2_ack_stable", stable_bad, 0);
      i_tx_ready = 1'b1;
      wait_tx(1);
      repeat (4) tick();
      check("w2_write_count", waq.size(), 1);
      if (waq.size() == 1) check("w2_data", wdq[0], 32'h5C);
      check("w2_tx_count", txq.size(), 1);
      if (txq.size() == 1) check("w2_ack", {24'd0, txq[0]}, 32'h06);
      clear_q();

      // Release, NAK while released, re-hold
      send_byte(8'h47);
      check("g_hold_before_ack", {31'd0, o_hold}, 32'd1);
      tick();
      check("g_hold_after_ack", {31'd0, o_hold}, 32'd0);
      check("g_tx_count", txq.size(), 1);
      if (txq.size() == 1) check("g_ack", {24'd0, txq[0]}, 32'h06);
      clear_q();
      send_byte(8'h57);
      wait_tx(1);
      send_seq('{8'h52, 8'h00});
      wait_tx(3);
      repeat (3) tick();
      check("nohold_tx_count", txq.size(), 3);
      if (txq.size() == 3) begin
         check("nohold_w_nak", {24'd0, txq[0]}, 32'h15);
         check("nohold_r_nak", {24'd0, txq[1]}, 32'h15);
         check("nohold_arg_nak", {24'd0, txq[2]}, 32'h15);
      end
      check("nohold_no_wr", waq.size(), 0);
      check("nohold_no_rd", raq.size(), 0);
      clear_q();
      send_byte(8'h48);
      wait_tx(1);
      tick();
      check("h_ack", (txq.size() == 1) ? {24'd0, txq[0]} : 32'hFFFF_FFFF, 32'h06);
      check("h_hold", {31'd0, o_hold}, 32'd1);
      clear_q();

      // Unknown opcode, then timeout mid-address
      send_byte(8'h00);
      wait_tx(1);
      tick();
      check("bad_op_nak", (txq.size() == 1) ? {24'd0, txq[0]} : 32'hFFFF_FFFF, 32'h15);
      clear_q();
      send_seq('{8'h57, 8'h00});
      repeat (TMO + 5) tick();
      check("tmo_no_tx", txq.size(), 0);
      check("tmo_no_wr", waq.size(), 0);
      send_seq('{8'h52, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01});
      wait_tx(2);
      repeat (3) tick();
      check("tmo_rd_count", raq.size(), 1);
      if (raq.size() == 1) check("tmo_rd_addr", raq[0], 32'h0);
      check("tmo_tx_count", txq.size(), 2);
      if (txq.size() == 2) begin
         check("tmo_tx0", {24'd0, txq[0]}, 32'h22);
         check("tmo_tx1", {24'd0, txq[1]}, 32'h06);
      end
      clear_q();

      // Reset during a pending write
      i_wr_ready = 1'b0;
      send_seq('{8'h57, 8'h00, 8'h30, 8'h00, 8'h00, 8'h01, 8'h77});
      check("rst_mid_wr_pending", {31'd0, o_wr_valid}, 32'd1);
      i_rst = 1'b1;
      tick();
      check("rst_mid_wr_valid", {31'd0, o_wr_valid}, 32'd0);
      check("rst_mid_hold", {31'd0, o_hold}, 32'd1);
      check("rst_mid_addr", o_addr, 32'h0);
      check("rst_mid_data", o_data, 32'h0);
      check("rst_mid_tx_valid", {31'd0, o_tx_valid}, 32'd0);
      check("rst_mid_rx_ready", {31'd0, o_rx_ready}, 32'd0);
      i_rst = 1'b0;
      i_wr_ready = 1'b1;
      repeat (10) tick();
      check("rst_mid_no_wr", waq.size(), 0);
      check("rst_mid_no_tx", txq.size(), 0);

      check("bus_invariants", viol, 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
